// File: rtl/fp_div_seq_if.sv
// ---------------------------------------------------------------------------
// fp_div_seq_if
// Operand/result bundle for the sequential single-precision divider. This is
// the same load/operand/result style as the sequential multiplier, so benches
// and the datapath wrapper can drive either unit through the same signals.
//
// Signals:
//   i_load  operand load/hold request (master -> slave)
//   i_a     dividend, IEEE-754 single (master -> slave)
//   i_b     divisor, IEEE-754 single (master -> slave)
//   o_res   quotient, held until the next completion (slave -> master)
//   o_done  one-cycle pulse when o_res updates (slave -> master)
//   o_busy  operation in flight (slave -> master)
// ---------------------------------------------------------------------------
interface fp_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             i_load;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [WIDTH-1:0] o_res;
  logic             o_done;
  logic             o_busy;

  modport master (
    output i_load, i_a, i_b,
    input  o_res, o_done, o_busy
  );

  modport slave (
    input  i_load, i_a, i_b,
    output o_res, o_done, o_busy
  );
endinterface

// File: rtl/fp_div_seq.sv
// ---------------------------------------------------------------------------
// fp_div_seq
// Sequential IEEE-754 single-precision divider computing o_res = i_a / i_b.
// A radix-2 restoring divider produces one quotient bit per cycle
// (24 significand bits + guard + round); sticky comes from the final
// remainder. Subnormal operands are normalised one bit per cycle, subnormal
// results are denormalised one bit per cycle, and the result is rounded
// to nearest, ties to even.
//
// Ports:
//   i_clk   clock, all state updates on the rising edge
//   i_rst   synchronous active-high reset; aborts any operation
//   bus     fp_div_seq_if.slave: i_load, i_a, i_b in; o_res, o_done, o_busy out
//
// Optional build macro:
//   FP_DIV_FTZ_EN  subnormal inputs are treated as signed zero and results
//                  with a non-positive biased exponent flush to signed zero;
//                  the NORM and SHIFT states are never visited.
// ---------------------------------------------------------------------------
module fp_div_seq #(
  parameter int WIDTH = 32,
  parameter int QBITS = 26
) (
  input  logic        i_clk,
  input  logic        i_rst,
  fp_div_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    NORM,
    DIV,
    SHIFT,
    ROUND,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Captured operands and working datapath
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             sign;
  logic [23:0]      ma;
  logic [23:0]      mb;
  logic signed [9:0] ea;
  logic signed [9:0] eb;
  logic signed [9:0] e;
  logic [24:0]      rem;
  logic [25:0]      q;
  logic             sticky;
  logic [4:0]       cnt;

  logic done;
  logic busy;

  // -------------------------------------------------------------------------
  // Operand unpacking and special-case classification
  // -------------------------------------------------------------------------
  logic [7:0]  a_exp;
  logic [7:0]  b_exp;
  logic [22:0] a_frac;
  logic [22:0] b_frac;
  logic        a_nan;
  logic        b_nan;
  logic        a_inf;
  logic        b_inf;
  logic        a_zero;
  logic        b_zero;
  logic        sign_in;
  logic [23:0] a_man;
  logic [23:0] b_man;
  logic signed [9:0] a_eff;
  logic signed [9:0] b_eff;

  assign a_exp   = a_reg[30:23];
  assign b_exp   = b_reg[30:23];
  assign a_frac  = a_reg[22:0];
  assign b_frac  = b_reg[22:0];
  assign sign_in = a_reg[31] ^ b_reg[31];

  assign a_nan = (&a_exp) && (|a_frac);
  assign b_nan = (&b_exp) && (|b_frac);
  assign a_inf = (&a_exp) && !(|a_frac);
  assign b_inf = (&b_exp) && !(|b_frac);

`ifdef FP_DIV_FTZ_EN
  assign a_zero = (a_exp == 8'd0);
  assign b_zero = (b_exp == 8'd0);
`else
  assign a_zero = (a_exp == 8'd0) && !(|a_frac);
  assign b_zero = (b_exp == 8'd0) && !(|b_frac);
`endif

  // A subnormal behaves as exponent 1 without the hidden bit
  assign a_man = {(a_exp != 8'd0), a_frac};
  assign b_man = {(b_exp != 8'd0), b_frac};
  assign a_eff = (a_exp == 8'd0) ? 10'sd1 : $signed({2'b00, a_exp});
  assign b_eff = (b_exp == 8'd0) ? 10'sd1 : $signed({2'b00, b_exp});

  logic        is_special;
  logic [31:0] special_res;

  // NaN-producing cases outrank infinities, which outrank zeros
  always_comb begin
    is_special  = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
    special_res = {sign_in, 31'd0};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_res = 32'hFFFF_FFFF;
    end else if (a_inf || b_zero) begin
      special_res = {sign_in, 8'hFF, 23'd0};
    end
  end

  // -------------------------------------------------------------------------
  // Quotient-range setup: pre-shift the dividend when ma < mb so that the
  // quotient always lands in [1,2) and its first bit is the hidden one.
  // -------------------------------------------------------------------------
  logic [23:0]       src_ma;
  logic [23:0]       src_mb;
  logic signed [9:0] src_ea;
  logic signed [9:0] src_eb;
  logic signed [9:0] e_base;
  logic signed [9:0] setup_e;
  logic [24:0]       setup_rem;

`ifdef FP_DIV_FTZ_EN
  assign src_ma = a_man;
  assign src_mb = b_man;
  assign src_ea = a_eff;
  assign src_eb = b_eff;
`else
  assign src_ma = ma;
  assign src_mb = mb;
  assign src_ea = ea;
  assign src_eb = eb;
`endif

  always_comb begin
    e_base = src_ea - src_eb + 10'sd127;
    if (src_ma < src_mb) begin
      setup_rem = {src_ma, 1'b0};
      setup_e   = e_base - 10'sd1;
    end else begin
      setup_rem = {1'b0, src_ma};
      setup_e   = e_base;
    end
  end

  logic norm_done;
  assign norm_done = ma[23] && mb[23];

  // -------------------------------------------------------------------------
  // Restoring divide step and denormalisation shift count
  // -------------------------------------------------------------------------
  logic        ge;
  logic [24:0] diff;
  logic [24:0] rem_next;
  logic        last_div;
  logic [4:0]  shift_amt;

  assign ge       = (rem >= {1'b0, mb});
  assign diff     = ge ? (rem - {1'b0, mb}) : rem;
  assign rem_next = diff << 1;
  assign last_div = (cnt == 5'(QBITS - 1));

  // 1 - e, saturated at 26; only the low five bits of e matter once e >= -25
  assign shift_amt = (e < -10'sd25) ? 5'd26 : (5'd1 - e[4:0]);

  // -------------------------------------------------------------------------
  // Round to nearest even. The exponent field and mantissa are added as one
  // word so a mantissa carry bumps the exponent, and a subnormal that rounds
  // up to 2^-126 lands on exponent 1 by itself.
  // -------------------------------------------------------------------------
  logic              round_up;
  logic [32:0]       round_sum;
  logic signed [9:0] rnd_exp;
  logic [31:0]       round_res;

  assign round_up  = q[1] && (q[0] || sticky || q[2]);
  assign round_sum = {e, q[24:2]} + 33'(round_up);
  assign rnd_exp   = round_sum[32:23];

  always_comb begin
    round_res = {sign, rnd_exp[7:0], round_sum[22:0]};
    if (rnd_exp >= 10'sd255) begin
      round_res = {sign, 8'hFF, 23'd0};
    end
`ifdef FP_DIV_FTZ_EN
    if (e <= 10'sd0) begin
      round_res = {sign, 31'd0};
    end
`endif
  end

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic; a load request restarts from any state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (bus.i_load) begin
      state_next = LOAD;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        LOAD: begin
          if (is_special) begin
            state_next = DONE;
          end else begin
`ifdef FP_DIV_FTZ_EN
            state_next = DIV;
`else
            state_next = NORM;
`endif
          end
        end
        NORM: begin
          if (norm_done) begin
            state_next = DIV;
          end
        end
        DIV: begin
          if (last_div) begin
`ifdef FP_DIV_FTZ_EN
            state_next = ROUND;
`else
            state_next = (e <= 10'sd0) ? SHIFT : ROUND;
`endif
          end
        end
        SHIFT: begin
          if (cnt == 5'd1) begin
            state_next = ROUND;
          end
        end
        ROUND:   state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM outputs
  // -------------------------------------------------------------------------
  always_comb begin
    done = 1'b0;
    busy = 1'b0;
    case (state)
      NORM, DIV, SHIFT, ROUND: busy = 1'b1;
      DONE:                    done = 1'b1;
      default: begin
        done = 1'b0;
        busy = 1'b0;
      end
    endcase
  end

  assign bus.o_done = done;
  assign bus.o_busy = busy;
  assign bus.o_res  = res_reg;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      sign    <= 1'b0;
      ma      <= '0;
      mb      <= '0;
      ea      <= '0;
      eb      <= '0;
      e       <= '0;
      rem     <= '0;
      q       <= '0;
      sticky  <= 1'b0;
      cnt     <= '0;
    end else begin
      if (bus.i_load) begin
        a_reg <= bus.i_a;
        b_reg <= bus.i_b;
      end

      // The result only moves on a real completion, so an aborted operation
      // never disturbs the held value
      if (state_next == DONE) begin
        res_reg <= (state == LOAD) ? special_res : round_res;
      end

      case (state)
        LOAD: begin
          if (!bus.i_load) begin
            sign <= sign_in;
            ma   <= a_man;
            mb   <= b_man;
            ea   <= a_eff;
            eb   <= b_eff;
`ifdef FP_DIV_FTZ_EN
            rem  <= setup_rem;
            e    <= setup_e;
            q    <= '0;
            cnt  <= '0;
`endif
          end
        end
        NORM: begin
          // Dividend first, then divisor, one bit per cycle
          if (!ma[23]) begin
            ma <= ma << 1;
            ea <= ea - 10'sd1;
          end else if (!mb[23]) begin
            mb <= mb << 1;
            eb <= eb - 10'sd1;
          end else begin
            rem <= setup_rem;
            e   <= setup_e;
            q   <= '0;
            cnt <= '0;
          end
        end
        DIV: begin
          q      <= {q[24:0], ge};
          rem    <= rem_next;
          sticky <= |diff;
          if (last_div) begin
            cnt <= shift_amt;
`ifndef FP_DIV_FTZ_EN
            if (e <= 10'sd0) begin
              e <= 10'sd0;
            end
`endif
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        SHIFT: begin
          q      <= q >> 1;
          sticky <= sticky | q[0];
          cnt    <= cnt - 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
